sdram_model: RTL and testbench

Synthesizable single-chip SDR SDRAM responder for simulation and loopback benches. It decodes the command bus driven by the `sdram` controller (ACTIVE, READ, WRITE, PRECHARGE, AUTO_REFRESH, LOAD_MODE, BURST_TERMINATE) and stores 16-bit words in internal RAM. It returns read bursts honouring the programmed CAS latency, burst length and burst type. It also raises sticky protocol and timing error flags so benches can check the controller against the device rules.

---
 rtl/sdram_model_if.sv | 11 +
 rtl/sdram_model.sv | 165 ++++++++++++++++
 tb/tb_sdram_model.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/sdram_model_if.sv
// sdram_model_if: SDRAM command/address bus between a controller and the device model.
interface sdram_model_if;
    logic [12:0] SDRAM_A;
    logic [1:0]  SDRAM_BA;
    logic        SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE;
    logic        SDRAM_DQML, SDRAM_DQMH, SDRAM_CKE;
    modport master (output SDRAM_A, SDRAM_BA, SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE,
                    SDRAM_DQML, SDRAM_DQMH, SDRAM_CKE);
    modport slave  (input  SDRAM_A, SDRAM_BA, SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE,
                    SDRAM_DQML, SDRAM_DQMH, SDRAM_CKE);
endinterface

// File: rtl/sdram_model.sv
// sdram_model: SDR SDRAM responder with burst read/write, init tracking and sticky protocol checks.
module sdram_model #(
    parameter int ROW_BITS = 4,
    parameter int COL_BITS = 9,
    parameter int TRCD     = 2,
    parameter int TRFC     = 7,
    parameter int TREFI    = 1024
) (
    input  logic          clk,
    input  logic          reset_n,
    inout  wire  [15:0]   SDRAM_DQ,
    sdram_model_if.slave  bus,
    output logic [12:0]   mode_reg,
    output logic          initialized,
    output logic [15:0]   refresh_count,
    output logic [7:0]    err
);
    localparam int AW = 2 + ROW_BITS + COL_BITS;
    localparam logic [7:0]  TRCD_C  = 8'(TRCD);
    localparam logic [7:0]  TRFC_C  = 8'(TRFC);
    localparam logic [15:0] TREFI_C = 16'(TREFI);
    typedef enum logic [2:0] {WAIT_PRE, WAIT_REF1, WAIT_REF2, WAIT_MODE, READY} init_t;
    init_t state, state_nx;
    logic [15:0] mem [2**AW];
    logic [3:0] open_q, open_nx;
    logic [ROW_BITS-1:0] row_q [4];
    logic [7:0] act_cnt [4];
    logic [7:0] rfc_cnt;
    logic [15:0] refi_cnt;
    logic b_act, b_wr, b_seq, b_ap, b_cl3;
    logic [ROW_BITS+1:0] b_base;
    logic [COL_BITS-1:0] b_col;
    logic [2:0] b_k, b_mask;
    logic s1_v, s1_cl3, s2_v, q_v;
    logic [15:0] s1_d, s2_d, q_d;
    logic [2:0] cmd, bl_mask;
    logic [1:0] ba, bl_code, beat_bank;
    logic [12:0] a;
    logic is_mrs, is_ref, is_pre, is_act, is_wr, is_rd, is_bst, ready, acc, cont, cl3, single_wr;
    logic beat_v, beat_wr, beat_last, beat_ap, beat_cl3;
    logic [AW-1:0] beat_addr;
    logic [7:0] err_nx;

    function automatic logic [COL_BITS-1:0] beat_col(input logic [COL_BITS-1:0] c,
                                                     input logic [2:0] k, m, input logic seq);
        logic [2:0] lo;
        lo = seq ? 3'(c[2:0] + k) : c[2:0] ^ k;
        return {c[COL_BITS-1:3], (c[2:0] & ~m) | (lo & m)};
    endfunction

    assign cmd = (!bus.SDRAM_nCS && bus.SDRAM_CKE) ? {bus.SDRAM_nRAS, bus.SDRAM_nCAS, bus.SDRAM_nWE} : 3'b111;
    assign {is_mrs, is_ref, is_pre, is_act} = {cmd == 3'd0, cmd == 3'd1, cmd == 3'd2, cmd == 3'd3};
    assign {is_wr, is_rd, is_bst} = {cmd == 3'd4, cmd == 3'd5, cmd == 3'd6};
    assign ba = bus.SDRAM_BA;
    assign a = bus.SDRAM_A;
    assign ready = state == READY;
    assign initialized = ready;
    assign acc = (is_rd || is_wr) && ready && open_q[ba];
    assign bl_code = mode_reg[2] ? 2'd0 : mode_reg[1:0];
    assign bl_mask = 3'((4'd1 << bl_code) - 4'd1);
    assign cl3 = mode_reg[6:4] == 3'd3;
    assign single_wr = is_wr && mode_reg[9];
    // A newly accepted READ/WRITE takes the beat slot; BURST_TERMINATE just drops the rest.
    assign cont = b_act && !acc && !is_bst;
    assign beat_v = acc || cont;
    assign beat_wr = acc ? is_wr : b_wr;
    assign beat_addr = acc ? {ba, row_q[ba], a[COL_BITS-1:0]} : {b_base, beat_col(b_col, b_k, b_mask, b_seq)};
    assign beat_last = acc ? (single_wr || bl_mask == 3'd0) : (b_k == b_mask);
    assign beat_ap = acc ? a[10] : b_ap;
    assign beat_cl3 = acc ? cl3 : b_cl3;
    assign beat_bank = beat_addr[AW-1 -: 2];
    assign SDRAM_DQ = (q_v && !is_wr) ? q_d : 16'hzzzz;

    always_comb begin
        state_nx = (state == WAIT_PRE  && is_pre && a[10]) ? WAIT_REF1 :
                   (state == WAIT_REF1 && is_ref)          ? WAIT_REF2 :
                   (state == WAIT_REF2 && is_ref)          ? WAIT_MODE :
                   (state == WAIT_MODE && is_mrs)          ? READY     : state;
        open_nx = open_q;
        if (beat_v && beat_last && beat_ap) open_nx[beat_bank] = 1'b0;
        if (is_pre) open_nx = a[10] ? 4'b0 : open_nx & ~(4'b1 << ba);
        if (is_act && ready) open_nx[ba] = 1'b1;
        err_nx[0] = (is_act || is_rd || is_wr) && !ready;
        err_nx[1] = (is_rd || is_wr) && ready && !open_q[ba];
        err_nx[2] = is_act && ready && open_q[ba];
        err_nx[3] = acc && act_cnt[ba] < TRCD_C;
        err_nx[4] = cmd != 3'b111 && rfc_cnt < TRFC_C;
        err_nx[5] = is_mrs && ((a[6:4] != 3'd2 && a[6:4] != 3'd3) || a[2] || (a[3] && a[2:0] == 3'd0));
        err_nx[6] = ready && refi_cnt > TREFI_C;
        err_nx[7] = is_mrs && |open_q;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= WAIT_PRE;
        else state <= state_nx;

    always_ff @(posedge clk)
        if (beat_v && beat_wr) begin
            if (!bus.SDRAM_DQML) mem[beat_addr][7:0] <= SDRAM_DQ[7:0];
            if (!bus.SDRAM_DQMH) mem[beat_addr][15:8] <= SDRAM_DQ[15:8];
        end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            mode_reg <= '0;
            refresh_count <= '0;
            err <= '0;
            open_q <= '0;
            rfc_cnt <= '1;
            refi_cnt <= '0;
            for (int i = 0; i < 4; i++) begin
                row_q[i] <= '0;
                act_cnt[i] <= '0;
            end
        end else begin
            open_q <= open_nx;
            err <= err | err_nx;
            if (is_mrs) mode_reg <= a;
            if (is_ref) refresh_count <= refresh_count + 16'd1;
            rfc_cnt <= is_ref ? 8'd1 : rfc_cnt + {7'd0, rfc_cnt != 8'hff};
            refi_cnt <= is_ref ? 16'd0 : refi_cnt + {15'd0, refi_cnt != 16'hffff};
            for (int i = 0; i < 4; i++)
                act_cnt[i] <= (is_act && ready && ba == 2'(i)) ? 8'd1 : act_cnt[i] + {7'd0, act_cnt[i] != 8'hff};
            if (is_act && ready) row_q[ba] <= a[ROW_BITS-1:0];
        end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            {b_act, b_wr, b_seq, b_ap, b_cl3} <= '0;
            b_base <= '0;
            b_col <= '0;
            b_k <= '0;
            b_mask <= '0;
        end else if (acc) begin
            b_act <= !(single_wr || bl_mask == 3'd0);
            b_wr <= is_wr;
            b_base <= {ba, row_q[ba]};
            b_col <= a[COL_BITS-1:0];
            b_k <= 3'd1;
            b_mask <= bl_mask;
            b_seq <= !mode_reg[3];
            b_ap <= a[10];
            b_cl3 <= cl3;
        end else if (cont) begin
            b_k <= b_k + 3'd1;
            b_act <= b_k != b_mask;
        end else b_act <= 1'b0;

    // Read beats go through one stage for CL2 and two for CL3; a WRITE flushes anything in flight.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            {s1_v, s1_cl3, s2_v, q_v} <= '0;
            s1_d <= '0;
            s2_d <= '0;
            q_d <= '0;
        end else begin
            s1_v <= beat_v && !beat_wr;
            s1_cl3 <= beat_cl3;
            s1_d <= mem[beat_addr];
            s2_v <= s1_v && s1_cl3 && !(acc && is_wr);
            s2_d <= s1_d;
            q_v <= !(acc && is_wr) && ((s1_v && !s1_cl3) || s2_v);
            q_d <= (s1_v && !s1_cl3) ? s1_d : s2_d;
        end
endmodule

// File: tb/tb_sdram_model.sv
// tb_sdram_model: directed checks of init, masked writes, burst ordering, error flags and reset.
module tb_sdram_model;
    localparam logic [2:0] MRS = 3'd0, REF = 3'd1, PRE = 3'd2, ACT = 3'd3, WR = 3'd4, RD = 3'd5;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic tb_oe = 1'b0;
    logic [15:0] tb_dq = '0;
    logic [12:0] mode_reg;
    logic initialized;
    logic [15:0] refresh_count;
    logic [7:0] err;
    wire [15:0] dq;
    int errors = 0;
    int checks = 0;
    logic [15:0] seq_exp [8] = '{16'hA0C6, 16'hA0C7, 16'hA0C0, 16'hA0C1, 16'hA0C2, 16'hA0C3, 16'hA0C4, 16'hA0EF};
    logic [15:0] il_exp  [8] = '{16'hA0C6, 16'hA0C7, 16'hA0C4, 16'hA0EF, 16'hA0C2, 16'hA0C3, 16'hA0C0, 16'hA0C1};

    sdram_model_if bus ();
    assign dq = tb_oe ? tb_dq : 16'hzzzz;
    for (genvar i = 0; i < 16; i++) begin : g_pu
        pullup (dq[i]);
    end

    sdram_model dut (
        .clk(clk), .reset_n(reset_n), .SDRAM_DQ(dq), .bus(bus),
        .mode_reg(mode_reg), .initialized(initialized), .refresh_count(refresh_count), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nops(input int n);
        repeat (n) tick();
    endtask

    task automatic issue(input logic [2:0] c, input logic [1:0] b, input logic [12:0] addr);
        bus.SDRAM_nCS = 1'b0;
        {bus.SDRAM_nRAS, bus.SDRAM_nCAS, bus.SDRAM_nWE} = c;
        bus.SDRAM_BA = b;
        bus.SDRAM_A = addr;
        tick();
        bus.SDRAM_nCS = 1'b1;
        {bus.SDRAM_nRAS, bus.SDRAM_nCAS, bus.SDRAM_nWE} = 3'b111;
        bus.SDRAM_DQML = 1'b0;
        bus.SDRAM_DQMH = 1'b0;
        tb_oe = 1'b0;
    endtask

    task automatic wr(input logic [1:0] b, input logic [12:0] addr, input logic [15:0] d, input logic mh);
        tb_dq = d;
        tb_oe = 1'b1;
        bus.SDRAM_DQMH = mh;
        issue(WR, b, addr);
    endtask

    task automatic init_seq();
        issue(PRE, 2'd0, 13'h400);
        nops(8);
        issue(REF, 2'd0, 13'h0);
        nops(8);
        issue(REF, 2'd0, 13'h0);
        nops(8);
        chk("init_before_mode", {15'd0, initialized}, 16'd0);
        issue(MRS, 2'd0, 13'h223);
        chk("initialized", {15'd0, initialized}, 16'd1);
        chk("mode_reg_init", {3'd0, mode_reg}, 16'h0223);
        chk("err_after_init", {8'd0, err}, 16'h00);
        chk("refresh_count_init", refresh_count, 16'd2);
    endtask

    initial begin
        {bus.SDRAM_nCS, bus.SDRAM_nRAS, bus.SDRAM_nCAS, bus.SDRAM_nWE} = 4'hF;
        {bus.SDRAM_DQML, bus.SDRAM_DQMH} = 2'b00;
        bus.SDRAM_CKE = 1'b1;
        bus.SDRAM_A = '0;
        bus.SDRAM_BA = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mode_reg", {3'd0, mode_reg}, 16'h0);
        chk("rst_initialized", {15'd0, initialized}, 16'd0);
        chk("rst_refresh_count", refresh_count, 16'd0);
        chk("rst_err", {8'd0, err}, 16'h0);
        chk("rst_dq_z", dq, 16'hFFFF);
        reset_n = 1'b1;
        tick();
        init_seq();
        issue(ACT, 2'd1, 13'd3);
        nops(1);
        for (int c = 0; c < 8; c++) wr(2'd1, 13'(c), 16'hA0C0 + 16'(c), 1'b0);
        wr(2'd1, 13'd5, 16'hBEEF, 1'b1);
        issue(RD, 2'd1, 13'd6);
        chk("seq_before_cl", dq, 16'hFFFF);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("seq_beat%0d", k), dq, seq_exp[k]);
        end
        tick();
        chk("seq_after_burst_z", dq, 16'hFFFF);
        chk("err_clean_seq", {8'd0, err}, 16'h00);
        issue(PRE, 2'd1, 13'h000);
        nops(1);
        issue(MRS, 2'd0, 13'h22B);
        chk("mode_reg_il", {3'd0, mode_reg}, 16'h022B);
        issue(ACT, 2'd1, 13'd3);
        nops(1);
        issue(RD, 2'd1, 13'd6);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("il_beat%0d", k), dq, il_exp[k]);
        end
        chk("err_clean_il", {8'd0, err}, 16'h00);
        issue(RD, 2'd1, 13'h405);
        tick();
        chk("ap_masked_beat0", dq, 16'hA0EF);
        tick();
        chk("ap_beat1", dq, 16'hA0C4);
        nops(8);
        issue(RD, 2'd1, 13'd0);
        tick();
        chk("closed_bank_dq_z", dq, 16'hFFFF);
        tick();
        chk("closed_bank_dq_z2", dq, 16'hFFFF);
        chk("err_closed_bank", {8'd0, err}, 16'h02);
        issue(ACT, 2'd2, 13'd0);
        issue(RD, 2'd2, 13'd0);
        nops(10);
        chk("err_trcd", {8'd0, err}, 16'h0A);
        issue(REF, 2'd0, 13'd0);
        nops(2);
        issue(ACT, 2'd0, 13'd0);
        chk("err_trfc", {8'd0, err}, 16'h1A);
        chk("refresh_count_3", refresh_count, 16'd3);
        nops(1000);
        chk("err_refi_not_yet", {8'd0, err}, 16'h1A);
        nops(100);
        chk("err_refi", {8'd0, err}, 16'h5A);
        issue(RD, 2'd2, 13'd1);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        chk("rst_mid_dq_z", dq, 16'hFFFF);
        chk("rst_mid_err", {8'd0, err}, 16'h0);
        chk("rst_mid_init", {15'd0, initialized}, 16'd0);
        chk("rst_mid_refcnt", refresh_count, 16'd0);
        tick();
        reset_n = 1'b1;
        tick();
        init_seq();
        issue(RD, 2'd2, 13'd1);
        tick();
        chk("post_rst_bank_closed_dq", dq, 16'hFFFF);
        chk("post_rst_bank_closed_err", {8'd0, err}, 16'h02);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
